full_subtractor: RTL and testbench
==================================

FULL_SUBTRACTOR -- requirements
Module: full_subtractor

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter WIDTH, default 1, SHALL set the operand width in bit-slices.
REQ-003 Parameter CNT_W, default 16, SHALL set the borrow-counter width.
REQ-004 Ports SHALL be exactly the following:
- clk        input   1       rising-edge clock
- rst        input   1       asynchronous active-high reset
- in0        input   WIDTH   minuend
- in1        input   WIDTH   subtrahend
- bin        input   1       borrow-in
- in_valid   input   1       capture strobe for the registered path
- sub        output  WIDTH   combinational difference
- bout       output  1       combinational borrow-out
- sub_q      output  WIDTH   registered difference
- bout_q     output  1       registered borrow-out
- zero_q     output  1       registered flag: sub_q==0 and bout_q==0
- out_valid  output  1       registered outputs updated this cycle
- borrow_cnt output  CNT_W   count of accepted operations with borrow (see Configuration)

Function
REQ-005 sub SHALL equal (in0 - in1 - bin) mod 2^WIDTH, purely combinational, zero latency, unaffected by clk and rst.
REQ-006 bout SHALL be 1 iff unsigned in0 < in1 + bin; for WIDTH=1 this means sub = in0^in1^bin and bout = (~in0&in1) | (~(in0^in1)&bin).
REQ-007 Multi-bit subtraction SHALL be a ripple chain: slice 0 takes bin, slice i takes the borrow-out of slice i-1, and bout is the borrow-out of slice WIDTH-1.
REQ-008 On a rising clk edge with in_valid=1, sub_q, bout_q and zero_q SHALL load the current sub, bout and zero result (one-cycle latency).
REQ-009 On a rising clk edge with in_valid=0, sub_q, bout_q and zero_q SHALL hold their values.
REQ-010 out_valid SHALL take the value of in_valid registered on every rising clk edge.
REQ-011 Inputs SHALL be accepted on every in_valid cycle; there is no back-pressure.
REQ-012 Back-to-back in_valid cycles SHALL each produce one out_valid cycle.

Reset
REQ-013 While rst=1, asynchronously and independent of clk: sub_q=0, bout_q=0, zero_q=0, out_valid=0, borrow_cnt=0.
REQ-014 An in_valid that coincides with rst=1 SHALL be discarded.
REQ-015 After rst deasserts, the first capture SHALL occur at the first rising edge with in_valid=1.

Configuration
REQ-016 The borrow-counter feature SHALL be controlled by macro FULL_SUBTRACTOR_STATS_EN.
REQ-017 With FULL_SUBTRACTOR_STATS_EN defined, borrow_cnt SHALL increment on each rising edge with in_valid=1 and bout=1, saturate at 2^CNT_W-1, and never wrap.
REQ-018 Without FULL_SUBTRACTOR_STATS_EN, the borrow_cnt port SHALL remain present, SHALL be driven constant 0, and no counter register SHALL be synthesised.

Structure
REQ-019 Package full_subtractor_pkg SHALL hold the default constants for WIDTH and CNT_W and the zero-flag helper function.
REQ-020 Sub-module full_subtractor_slice (one-bit cell: in0, in1, bin -> sub, bout) SHALL be instantiated WIDTH times by a generate loop.

Verification
REQ-021 WIDTH=1, all eight in0/in1/bin combinations with 10 ns hold each -> (sub,bout) = 000:(0,0), 001:(1,1), 010:(1,1), 011:(0,1), 100:(1,0), 101:(0,0), 110:(0,0), 111:(1,1).
REQ-022 WIDTH=4, in0=4'h3, in1=4'h5, bin=1 -> sub=4'hD, bout=1; in0=4'h9, in1=4'h4, bin=0 -> sub=4'h5, bout=0.
REQ-023 in_valid pulse with in0=1, in1=1, bin=0 -> next edge: sub_q=0, bout_q=0, zero_q=1, out_valid=1; following idle edge: out_valid=0 and values held.
REQ-024 Assert rst between clock edges while out_valid=1 -> all registered outputs and borrow_cnt go to 0 immediately; combinational sub/bout are unchanged.
REQ-025 STATS_EN defined, CNT_W=2, five accepted operations with bout=1 -> borrow_cnt=3 (saturated); without the macro -> borrow_cnt=0 throughout.

Source files
------------

// File: rtl/full_subtractor_pkg.sv
// Shared defaults and the zero-flag helper for the full_subtractor slice.
package full_subtractor_pkg;

    localparam int DEFAULT_WIDTH = 1;
    localparam int DEFAULT_CNT_W = 16;
    localparam int MAX_W         = 64;

    // A result is "zero" only when both the difference and the borrow are clear.
    function automatic logic zero_flag(input logic [MAX_W-1:0] diff, input logic borrow);
        return (diff == '0) && !borrow;
    endfunction

endpackage

// File: rtl/full_subtractor_slice.sv
// One-bit full-subtractor cell: difference and borrow-out of in0 - in1 - bin.
module full_subtractor_slice (
    input  logic in0,
    input  logic in1,
    input  logic bin,
    output logic sub,
    output logic bout
);

    assign sub  = in0 ^ in1 ^ bin;
    assign bout = (~in0 & in1) | (~(in0 ^ in1) & bin);

endmodule

// File: rtl/full_subtractor.sv
// Ripple-borrow subtractor with a registered result stage and an optional
// saturating borrow counter enabled by FULL_SUBTRACTOR_STATS_EN.
module full_subtractor
    import full_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic             bin,
    input  logic             in_valid,
    output logic [WIDTH-1:0] sub,
    output logic             bout,
    output logic [WIDTH-1:0] sub_q,
    output logic             bout_q,
    output logic             zero_q,
    output logic             out_valid,
    output logic [CNT_W-1:0] borrow_cnt
);

    logic [WIDTH:0]   brw_p0;
    logic             zero_p0;
    logic [WIDTH-1:0] sub_p1;
    logic             bout_p1;
    logic             zero_p1;
    logic             vld_p1;

    assign brw_p0[0] = bin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_slice
        full_subtractor_slice u_slice (
            .in0  (in0[i]),
            .in1  (in1[i]),
            .bin  (brw_p0[i]),
            .sub  (sub[i]),
            .bout (brw_p0[i+1])
        );
    end

    assign bout    = brw_p0[WIDTH];
    assign zero_p0 = zero_flag(MAX_W'(sub), bout);

    // p0 -> p1: capture the combinational result on each accepted operation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sub_p1  <= '0;
            bout_p1 <= 1'b0;
            zero_p1 <= 1'b0;
            vld_p1  <= 1'b0;
        end else begin
            vld_p1 <= in_valid;
            if (in_valid) begin
                sub_p1  <= sub;
                bout_p1 <= bout;
                zero_p1 <= zero_p0;
            end
        end
    end

    assign sub_q     = sub_p1;
    assign bout_q    = bout_p1;
    assign zero_q    = zero_p1;
    assign out_valid = vld_p1;

`ifdef FULL_SUBTRACTOR_STATS_EN
    logic [CNT_W-1:0] cnt_p1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_p1 <= '0;
        end else if (in_valid && bout) begin
            cnt_p1 <= sat_inc(cnt_p1);
        end
    end

    assign borrow_cnt = cnt_p1;
`else
    assign borrow_cnt = '0;
`endif

endmodule

// File: tb/tb_full_subtractor.sv
// Randomised self-checking bench for full_subtractor (1-bit and 4-bit builds).
module tb_full_subtractor;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

`ifdef FULL_SUBTRACTOR_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    // 1-bit instance with a 2-bit counter
    logic       a1, b1, c1, v1;
    logic       s1, bo1, sq1, bq1, zq1, ov1;
    logic [1:0] cnt1;

    // 4-bit instance with an 8-bit counter
    logic [3:0] a4, b4;
    logic       c4, v4;
    logic [3:0] s4, sq4;
    logic       bo4, bq4, zq4, ov4;
    logic [7:0] cnt4;

    int vectors = 0;
    int miscompares = 0;

    // reference model state
    logic       m1_sq, m1_bq, m1_zq, m1_ov;
    int         m1_cnt;
    logic [3:0] m4_sq;
    logic       m4_bq, m4_zq, m4_ov;
    int         m4_cnt;

    full_subtractor #(.WIDTH(1), .CNT_W(2)) dut1 (
        .clk(clk), .rst(rst), .in0(a1), .in1(b1), .bin(c1), .in_valid(v1),
        .sub(s1), .bout(bo1), .sub_q(sq1), .bout_q(bq1), .zero_q(zq1),
        .out_valid(ov1), .borrow_cnt(cnt1)
    );

    full_subtractor #(.WIDTH(4), .CNT_W(8)) dut4 (
        .clk(clk), .rst(rst), .in0(a4), .in1(b4), .bin(c4), .in_valid(v4),
        .sub(s4), .bout(bo4), .sub_q(sq4), .bout_q(bq4), .zero_q(zq4),
        .out_valid(ov4), .borrow_cnt(cnt4)
    );

    task automatic model_reset();
        m1_sq = 1'b0; m1_bq = 1'b0; m1_zq = 1'b0; m1_ov = 1'b0; m1_cnt = 0;
        m4_sq = 4'd0; m4_bq = 1'b0; m4_zq = 1'b0; m4_ov = 1'b0; m4_cnt = 0;
    endtask

    // Advance one rising edge, update the model from the applied operands, settle.
    task automatic model_edge();
        int d;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            m1_ov = v1;
            if (v1) begin
                d = int'(a1) - int'(b1) - int'(c1);
                m1_sq = 1'((d + 2) % 2);
                m1_bq = (d < 0);
                m1_zq = (m1_sq == 1'b0) && !m1_bq;
                if (m1_bq && m1_cnt < 3) m1_cnt++;
            end
            m4_ov = v4;
            if (v4) begin
                d = int'(a4) - int'(b4) - int'(c4);
                m4_sq = 4'((d + 16) % 16);
                m4_bq = (d < 0);
                m4_zq = (m4_sq == 4'd0) && !m4_bq;
                if (m4_bq && m4_cnt < 255) m4_cnt++;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        a1 = 0; b1 = 0; c1 = 0; v1 = 0;
        a4 = 0; b4 = 0; c4 = 0; v4 = 0;
        rst = 1'b0;
        #1 rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({sq1, bq1, zq1, ov1, cnt1} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_d1 got %b want 000000", {sq1, bq1, zq1, ov1, cnt1});
        end
        vectors++;
        if ({sq4, bq4, zq4, ov4, cnt4} !== 15'b0) begin
            miscompares++;
            $display("FAIL reset_d4 got %b want 0", {sq4, bq4, zq4, ov4, cnt4});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_truth_table();
        logic [1:0] tt [8];
        tt = '{2'b00, 2'b11, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 2'b11};
        for (int i = 0; i < 8; i++) begin
            {a1, b1, c1} = 3'(i);
            #10;
            vectors++;
            if ({s1, bo1} !== tt[i]) begin
                miscompares++;
                $display("FAIL truth_%0d got sub,bout=%b want %b", i, {s1, bo1}, tt[i]);
            end
        end
        // the registered stage must not have moved while in_valid was low
        vectors++;
        if ({sq1, bq1, zq1, ov1} !== 4'b0) begin
            miscompares++;
            $display("FAIL truth_hold got %b want 0000", {sq1, bq1, zq1, ov1});
        end
    endtask

    task automatic test_w4_vectors();
        a4 = 4'h3; b4 = 4'h5; c4 = 1'b1;
        #10;
        vectors++;
        if ({s4, bo4} !== {4'hD, 1'b1}) begin
            miscompares++;
            $display("FAIL w4_3m5m1 got %h/%b want d/1", s4, bo4);
        end
        a4 = 4'h9; b4 = 4'h4; c4 = 1'b0;
        #10;
        vectors++;
        if ({s4, bo4} !== {4'h5, 1'b0}) begin
            miscompares++;
            $display("FAIL w4_9m4 got %h/%b want 5/0", s4, bo4);
        end
    endtask

    task automatic test_capture();
        @(negedge clk);
        a4 = 4'd1; b4 = 4'd1; c4 = 1'b0; v4 = 1'b1;
        model_edge();
        vectors++;
        if ({sq4, bq4, zq4, ov4} !== {4'd0, 1'b0, 1'b1, 1'b1}) begin
            miscompares++;
            $display("FAIL capture got %b want 0000011", {sq4, bq4, zq4, ov4});
        end
        @(negedge clk);
        v4 = 1'b0; a4 = 4'd7; b4 = 4'd2;
        model_edge();
        vectors++;
        if ({sq4, bq4, zq4, ov4} !== {4'd0, 1'b0, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL capture_hold got %b want 0000010", {sq4, bq4, zq4, ov4});
        end
    endtask

    task automatic test_back_to_back();
        int d;
        logic [3:0] exp_s;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            a1 = 1'($urandom); b1 = 1'($urandom); c1 = 1'($urandom);
            v1 = ($urandom_range(3) != 0);
            a4 = 4'($urandom); b4 = 4'($urandom); c4 = 1'($urandom);
            v4 = (n < 20) ? 1'b1 : ($urandom_range(3) != 0);
            d = int'(a4) - int'(b4) - int'(c4);
            exp_s = 4'((d + 16) % 16);
            #1;
            vectors++;
            if ({s4, bo4} !== {exp_s, (d < 0)}) begin
                miscompares++;
                $display("FAIL comb_%0d got %h/%b want %h/%b", n, s4, bo4, exp_s, (d < 0));
            end
            model_edge();
            vectors++;
            if ({sq1, bq1, zq1, ov1, cnt1} !== {m1_sq, m1_bq, m1_zq, m1_ov, (STATS ? 2'(m1_cnt) : 2'd0)}) begin
                miscompares++;
                $display("FAIL rand_d1_%0d got %b want %b", n, {sq1, bq1, zq1, ov1, cnt1},
                         {m1_sq, m1_bq, m1_zq, m1_ov, (STATS ? 2'(m1_cnt) : 2'd0)});
            end
            vectors++;
            if ({sq4, bq4, zq4, ov4, cnt4} !== {m4_sq, m4_bq, m4_zq, m4_ov, (STATS ? 8'(m4_cnt) : 8'd0)}) begin
                miscompares++;
                $display("FAIL rand_d4_%0d got %b want %b", n, {sq4, bq4, zq4, ov4, cnt4},
                         {m4_sq, m4_bq, m4_zq, m4_ov, (STATS ? 8'(m4_cnt) : 8'd0)});
            end
        end
    endtask

    task automatic test_saturation();
        @(negedge clk);
        v1 = 1'b0; v4 = 1'b0;
        rst = 1'b1;
        model_reset();
        #1 rst = 1'b0;
        a1 = 1'b0; b1 = 1'b1; c1 = 1'b0; v1 = 1'b1;
        a4 = 4'd0; b4 = 4'd1; c4 = 1'b0; v4 = 1'b1;
        repeat (5) model_edge();
        vectors++;
        if (cnt1 !== (STATS ? 2'd3 : 2'd0)) begin
            miscompares++;
            $display("FAIL sat_cnt1 got %0d want %0d", cnt1, (STATS ? 3 : 0));
        end
        vectors++;
        if (cnt4 !== (STATS ? 8'd5 : 8'd0)) begin
            miscompares++;
            $display("FAIL cnt4 got %0d want %0d", cnt4, (STATS ? 5 : 0));
        end
        @(negedge clk);
        v1 = 1'b0; v4 = 1'b0;
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        a4 = 4'h3; b4 = 4'h5; c4 = 1'b1; v4 = 1'b1;
        a1 = 1'b1; b1 = 1'b0; c1 = 1'b0; v1 = 1'b1;
        model_edge();
        #2 rst = 1'b1;
        model_reset();
        #1;
        vectors++;
        if ({sq4, bq4, zq4, ov4, cnt4, sq1, bq1, zq1, ov1, cnt1} !== 21'b0) begin
            miscompares++;
            $display("FAIL async_rst got %b/%b want all zero",
                     {sq4, bq4, zq4, ov4, cnt4}, {sq1, bq1, zq1, ov1, cnt1});
        end
        vectors++;
        if ({s4, bo4, s1, bo1} !== {4'hD, 1'b1, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL async_rst_comb got %h/%b %b/%b want d/1 1/0", s4, bo4, s1, bo1);
        end
        // an in_valid edge during reset must be dropped
        @(posedge clk);
        #1;
        vectors++;
        if ({ov4, ov1, sq4, bq4} !== 7'b0) begin
            miscompares++;
            $display("FAIL rst_discard got %b want 0000000", {ov4, ov1, sq4, bq4});
        end
        @(negedge clk);
        rst = 1'b0; v4 = 1'b0; v1 = 1'b0;
        model_edge();
        vectors++;
        if ({sq4, bq4, zq4, ov4} !== 7'b0) begin
            miscompares++;
            $display("FAIL post_rst_idle got %b want 0000000", {sq4, bq4, zq4, ov4});
        end
        @(negedge clk);
        a4 = 4'h9; b4 = 4'h4; c4 = 1'b0; v4 = 1'b1;
        model_edge();
        vectors++;
        if ({sq4, bq4, zq4, ov4, cnt4} !== {4'h5, 1'b0, 1'b0, 1'b1, 8'd0}) begin
            miscompares++;
            $display("FAIL first_capture got %b want %b", {sq4, bq4, zq4, ov4, cnt4},
                     {4'h5, 1'b0, 1'b0, 1'b1, 8'd0});
        end
    endtask

    initial begin
        test_reset();
        test_truth_table();
        test_w4_vectors();
        test_capture();
        test_back_to_back();
        test_saturation();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
